// File: rtl/serial_sub_if.sv
// ---------------------------------------------------------------------------
// serial_sub_if : start/busy/done handshake and operand/result bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub : bit-serial a - b - bin, one full-subtractor cell, LSB first
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  wire logic    clk,
  input  wire logic    rst,
  serial_sub_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             abit, bbit, dbit, brn, last;

  // Operands shift right so the bit under the cell is always at index 0.
  assign abit = a_q[0];
  assign bbit = b_q[0];
  assign dbit = abit ^ bbit ^ br_q;
  assign brn  = (~abit & bbit) | (~(abit ^ bbit) & br_q);
  assign last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = brn;
        res_d = {dbit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // br_q here is the borrow entering the MSB cell.
          diff_d  = {dbit, res_q[WIDTH-1:1]};
          bout_d  = brn;
          ovf_d   = br_q ^ brn;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub : scoreboard bench for serial_sub at WIDTH=8 and WIDTH=2
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) if8 ();
  serial_sub_if #(.WIDTH(2)) if2 ();

  serial_sub #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));
  serial_sub #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  int checks = 0;
  int errors = 0;

  logic [9:0] q8[$];
  logic [3:0] q2[$];

  // Monitors: pop expected result whenever done is presented
  always @(negedge clk) begin
    logic [9:0] e8;
    checks++;
    if (if8.busy && if8.done) begin
      errors++;
      $display("FAIL inv8 busy=%0b done=%0b required not both high", if8.busy, if8.done);
    end
    if (if8.done) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected diff=%h bout=%0b ovf=%0b required no done", if8.diff, if8.bout, if8.ovf);
      end else begin
        e8 = q8.pop_front();
        if ({if8.diff, if8.bout, if8.ovf} !== e8) begin
          errors++;
          $display("FAIL result8 got diff=%h bout=%0b ovf=%0b required diff=%h bout=%0b ovf=%0b",
                   if8.diff, if8.bout, if8.ovf, e8[9:2], e8[1], e8[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e2;
    if (if2.done) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL done2_unexpected diff=%h required no done", if2.diff);
      end else begin
        e2 = q2.pop_front();
        if ({if2.diff, if2.bout, if2.ovf} !== e2) begin
          errors++;
          $display("FAIL result2 got diff=%h bout=%0b ovf=%0b required diff=%h bout=%0b ovf=%0b",
                   if2.diff, if2.bout, if2.ovf, e2[3:2], e2[1], e2[0]);
        end
      end
    end
  end

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, input logic eo, input bit push);
    if (push) q8.push_back({ed, eb, eo});
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin = bi;
    @(posedge clk); #1;
    if8.start = 1'b0;
  endtask

  task automatic wait_done8();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (if8.done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout8 done=0 required done within 20 cycles");
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb, input logic eo);
    start8(a, b, bi, ed, eb, eo, 1);
    wait_done8();
    @(posedge clk); #1;
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic bi,
                      input logic [1:0] ed, input logic eb, input logic eo);
    bit seen = 0;
    q2.push_back({ed, eb, eo});
    if2.start = 1'b1; if2.a = a; if2.b = b; if2.bin = bi;
    @(posedge clk); #1;
    if2.start = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (if2.done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout2 done=0 required done within 10 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  initial begin
    int busy_cnt;
    if8.start = 0; if8.a = '0; if8.b = '0; if8.bin = 0;
    if2.start = 0; if2.a = '0; if2.b = '0; if2.bin = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset8_outs", {if8.busy, if8.done, if8.diff, if8.bout, if8.ovf}, 32'h0);
    chk("reset2_outs", {if2.busy, if2.done, if2.diff, if2.bout, if2.ovf}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Positive result with busy/done timing
    start8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1);
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (if8.busy && !if8.done) busy_cnt++;
    end
    @(posedge clk); #1;
    chk("busy_cycles", busy_cnt, 8);
    chk("done_at_E8", {if8.busy, if8.done}, 2'b01);
    @(posedge clk); #1;
    chk("done_one_cycle", {if8.busy, if8.done}, 2'b00);

    run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start pulse and operand changes mid-RUN are ignored
    start8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1);
    repeat (2) begin @(posedge clk); #1; end
    if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'h00; if8.bin = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0; if8.a = 8'h33; if8.b = 8'h77;
    chk("start_ignored_busy", if8.busy, 1'b1);
    wait_done8();
    @(posedge clk); #1;

    // Back-to-back: start held in the DONE cycle
    start8(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1);
    wait_done8();
    start8(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0, 1);
    chk("b2b_edge", {if8.busy, if8.done}, 2'b10);
    wait_done8();
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN
    start8(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {if8.busy, if8.done, if8.diff, if8.bout, if8.ovf}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    chk("rst_no_done_pending", q8.size(), 0);
    run8(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

    // Exhaustive WIDTH=2 against a signed/unsigned arithmetic model
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          int full, sa, sb, sd;
          full = ia - ib - ic;
          sa = (ia >= 2) ? ia - 4 : ia;
          sb = (ib >= 2) ? ib - 4 : ib;
          sd = sa - sb - ic;
          run2(2'(ia), 2'(ib), 1'(ic), 2'(full), (full < 0), (sd < -2 || sd > 1));
        end

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout required finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
